// File: rtl/tenkey_pkg.sv
// -----------------------------------------------------------------------------
// tenkey_pkg
// Shared definitions for the tenkey producer: key-line and digit widths, the
// close request code and the driver state encoding.
// Optional feature macro used by the files that import this package:
//   TENKEY_CLOSE_EN - makes CLOSE_CODE a legal digit that raises 'close'.
// -----------------------------------------------------------------------------
package tenkey_pkg;

   localparam int TENKEY_W = 10;
   localparam int DIGIT_W  = 4;

   localparam logic [DIGIT_W-1:0] CLOSE_CODE = 4'hC;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      GAP   = 2'd2
   } state_e;

   // True for a plain decimal digit 0..9.
   function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
      return (d <= 4'd9);
   endfunction

endpackage

// File: rtl/tenkey_dec.sv
// -----------------------------------------------------------------------------
// tenkey_dec
// Combinational decoder from a BCD digit to one-hot tenkey lines.
// Ports:
//   digit_i   - digit code (0..9 decimal keys, CLOSE_CODE when enabled)
//   onehot_o  - one-hot key lines, all zero for any non-decimal code
//   legal_o   - code may be accepted as a key press
//   close_o   - code is the close request
// Optional feature: TENKEY_CLOSE_EN makes CLOSE_CODE legal; without it the
// close code is treated like every other illegal code.
// -----------------------------------------------------------------------------
module tenkey_dec
   import tenkey_pkg::*;
(
   input  logic [DIGIT_W-1:0]  digit_i,
   output logic [TENKEY_W-1:0] onehot_o,
   output logic                legal_o,
   output logic                close_o
);

   // Digit classification and one-hot decode.
   always_comb begin
      onehot_o = '0;
      legal_o  = 1'b0;
      close_o  = 1'b0;
      if (is_bcd(digit_i)) begin
         onehot_o = TENKEY_W'(1'b1) << digit_i;
         legal_o  = 1'b1;
      end else begin
`ifdef TENKEY_CLOSE_EN
         if (digit_i == CLOSE_CODE) begin
            legal_o = 1'b1;
            close_o = 1'b1;
         end else begin
            legal_o = 1'b0;
         end
`else
         legal_o = 1'b0;
`endif
      end
   end

endmodule

// File: rtl/tenkey_driver_chk.sv
// -----------------------------------------------------------------------------
// tenkey_driver_chk
// Elaboration-time checks on the tenkey_driver timing parameters. The press
// and gap counters are 8 bits wide and count down to zero, so both lengths
// must lie in 1..255.
// Ports: none.
// -----------------------------------------------------------------------------
module tenkey_driver_chk #(
   parameter int PRESS_CYCLES = 4,
   parameter int GAP_CYCLES   = 2
) ();

   if ((PRESS_CYCLES < 1) || (PRESS_CYCLES > 255)) begin : g_bad_press
      $error("tenkey_driver: PRESS_CYCLES out of range 1..255");
   end

   if ((GAP_CYCLES < 1) || (GAP_CYCLES > 255)) begin : g_bad_gap
      $error("tenkey_driver: GAP_CYCLES out of range 1..255");
   end

endmodule

// File: rtl/tenkey_driver.sv
// -----------------------------------------------------------------------------
// tenkey_driver
// Producer end of the tenkey interface. Accepts digits over valid/ready,
// holds the decoded key for PRESS_CYCLES cycles, then keeps all key lines low
// for GAP_CYCLES cycles before the next digit can be accepted.
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   digit        - digit to press (held stable by upstream until accepted)
//   digit_valid  - digit is presented
//   digit_ready  - driver accepts a digit this cycle (IDLE and out of reset)
//   tenkey       - one-hot key lines, nonzero only while pressing
//   close        - close request, held like a key press
//   busy         - pressing or in the release gap
//   err          - one-cycle pulse when an illegal digit is accepted
// Optional feature: TENKEY_CLOSE_EN enables the close code. Without it the
// decoder never reports a close, so 'close' stays at its reset value of 0.
// -----------------------------------------------------------------------------
module tenkey_driver
   import tenkey_pkg::*;
#(
   parameter int PRESS_CYCLES = 4,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DIGIT_W-1:0]  digit,
   input  logic                digit_valid,
   output logic                digit_ready,
   output logic [TENKEY_W-1:0] tenkey,
   output logic                close,
   output logic                busy,
   output logic                err
);

   // Counters are loaded with length-1 and the phase ends when they hit 0.
   localparam logic [7:0] PRESS_LOAD = 8'(PRESS_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

   state_e                state_q;
   logic [7:0]            cnt_q;
   logic [7:0]            cnt_d;
   logic [TENKEY_W-1:0]   tenkey_q;
   logic                  close_q;
   logic                  err_q;

   logic [TENKEY_W-1:0]   dec_onehot_s;
   logic                  dec_legal_s;
   logic                  dec_close_s;
   logic                  accept_s;

   tenkey_driver_chk #(
      .PRESS_CYCLES (PRESS_CYCLES),
      .GAP_CYCLES   (GAP_CYCLES)
   ) u_chk ();

   tenkey_dec u_dec (
      .digit_i  (digit),
      .onehot_o (dec_onehot_s),
      .legal_o  (dec_legal_s),
      .close_o  (dec_close_s)
   );

   // Ready is dropped while rst_n is low so nothing is offered during reset.
   assign digit_ready = rst_n && (state_q == IDLE);
   assign accept_s    = digit_valid && digit_ready;
   assign cnt_d       = cnt_q - 8'd1;

   // Press/gap sequencer with registered key, close and error outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         tenkey_q <= '0;
         close_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  if (dec_legal_s) begin
                     state_q  <= PRESS;
                     cnt_q    <= PRESS_LOAD;
                     tenkey_q <= dec_onehot_s;
                     close_q  <= dec_close_s;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            PRESS: begin
               if (cnt_q == 8'd0) begin
                  state_q  <= GAP;
                  cnt_q    <= GAP_LOAD;
                  tenkey_q <= '0;
                  close_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            GAP: begin
               if (cnt_q == 8'd0) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q  <= IDLE;
               cnt_q    <= 8'd0;
               tenkey_q <= '0;
               close_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tenkey = tenkey_q;
   assign close  = close_q;
   assign err    = err_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_tenkey_driver.sv
// -----------------------------------------------------------------------------
// tb_tenkey_driver
// Self-checking bench for tenkey_driver. The main instance (4/2 timing) is
// tracked every cycle by a timeline model: each accepted digit writes its
// expected key/close/err values into per-cycle arrays and moves the cycle at
// which the driver is expected to be ready again. A second instance with
// 1/1 timing covers the shortest legal press and gap.
// Honours TENKEY_CLOSE_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_tenkey_driver;

   localparam int P = 4;
   localparam int G = 2;
   localparam int NCYC = 8192;
`ifdef TENKEY_CLOSE_EN
   localparam bit CLOSE_EN = 1'b1;
`else
   localparam bit CLOSE_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] digit;
   logic       digit_valid;
   logic       digit_ready;
   logic [9:0] tenkey;
   logic       close;
   logic       busy;
   logic       err;

   logic [3:0] d1_digit;
   logic       d1_valid;
   logic       d1_ready;
   logic [9:0] d1_tenkey;
   logic       d1_close;
   logic       d1_busy;
   logic       d1_err;

   always #5 clk = ~clk;

   tenkey_driver #(.PRESS_CYCLES(P), .GAP_CYCLES(G)) dut (
      .clk(clk), .rst_n(rst_n), .digit(digit), .digit_valid(digit_valid),
      .digit_ready(digit_ready), .tenkey(tenkey), .close(close),
      .busy(busy), .err(err)
   );

   tenkey_driver #(.PRESS_CYCLES(1), .GAP_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .digit(d1_digit), .digit_valid(d1_valid),
      .digit_ready(d1_ready), .tenkey(d1_tenkey), .close(d1_close),
      .busy(d1_busy), .err(d1_err)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ready_at = 0;

   logic [9:0] exp_tk [0:NCYC-1];
   logic       exp_cl [0:NCYC-1];
   logic       exp_er [0:NCYC-1];

   typedef struct {
      logic [3:0] d;
      logic [9:0] tk;
      logic       er;
      logic       cl;
      logic       bz;
   } vec_t;

   vec_t tbl [0:8];

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
      end
   endtask

   task automatic check_all();
      chk("tenkey", tenkey, exp_tk[cyc]);
      chk1("close", close, exp_cl[cyc]);
      chk1("err", err, exp_er[cyc]);
      chk1("ready", digit_ready, rst_n && (cyc >= ready_at));
      chk1("busy", busy, rst_n && (cyc < ready_at));
   endtask

   // One clock: book any accept into the timeline, advance, check.
   task automatic tick(output bit acc);
      int         a;
      logic [9:0] one;
      one = 10'd1;
      acc = 1'b0;
      if (rst_n === 1'b1 && digit_valid === 1'b1 && cyc >= ready_at) begin
         acc = 1'b1;
         a   = cyc + 1;
         if (digit <= 4'd9) begin
            for (int k = 0; k < P; k++) exp_tk[a+k] = one << digit;
            ready_at = a + P + G;
         end else if (CLOSE_EN && digit == 4'hC) begin
            for (int k = 0; k < P; k++) exp_cl[a+k] = 1'b1;
            ready_at = a + P + G;
         end else begin
            exp_er[a] = 1'b1;
         end
      end
      @(posedge clk);
      cyc++;
      if (cyc >= NCYC - 32) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC - 32);
         $fatal(1, "cycle budget exhausted");
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic wait_ready();
      bit acc;
      int n;
      n = 0;
      while (!(rst_n && cyc >= ready_at) && n < 50) begin
         tick(acc);
         n++;
      end
      if (n >= 50) begin
         checks++;
         failures++;
         $display("FAIL wait_ready cyc=%0d actual=timeout required=ready", cyc);
      end
   endtask

   // Asynchronous reset in the middle of a cycle, checked before any edge.
   task automatic apply_reset();
      bit acc;
      rst_n = 1'b0;
      #1;
      chk("rst_tenkey", tenkey, 10'h000);
      chk1("rst_ready", digit_ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err, 1'b0);
      for (int k = 0; k < 24; k++) begin
         exp_tk[cyc+k] = 10'h000;
         exp_cl[cyc+k] = 1'b0;
         exp_er[cyc+k] = 1'b0;
      end
      ready_at = cyc;
      tick(acc);
      tick(acc);
      rst_n = 1'b1;
      #1;
      chk1("rst_release_ready", digit_ready, 1'b1);
   endtask

   initial begin
      bit acc;
      int n_a;
      int n_b;

      for (int i = 0; i < NCYC; i++) begin
         exp_tk[i] = 10'h000;
         exp_cl[i] = 1'b0;
         exp_er[i] = 1'b0;
      end
      tbl[0] = '{4'd0, 10'h001, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{4'd1, 10'h002, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{4'd5, 10'h020, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{4'd7, 10'h080, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{4'd9, 10'h200, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{4'hA, 10'h000, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{4'hB, 10'h000, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{4'hF, 10'h000, 1'b1, 1'b0, 1'b0};
`ifdef TENKEY_CLOSE_EN
      tbl[8] = '{4'hC, 10'h000, 1'b0, 1'b1, 1'b1};
`else
      tbl[8] = '{4'hC, 10'h000, 1'b1, 1'b0, 1'b0};
`endif

      rst_n       = 1'b0;
      digit       = 4'd0;
      digit_valid = 1'b0;
      d1_digit    = 4'd0;
      d1_valid    = 1'b0;
      repeat (3) tick(acc);
      rst_n = 1'b1;
      #1;
      check_all();

      // Single-digit table: first output cycle against fixed expectations.
      for (int i = 0; i < 9; i++) begin
         wait_ready();
         digit       = tbl[i].d;
         digit_valid = 1'b1;
         tick(acc);
         digit_valid = 1'b0;
         chk("tbl_tenkey", tenkey, tbl[i].tk);
         chk1("tbl_err", err, tbl[i].er);
         chk1("tbl_close", close, tbl[i].cl);
         chk1("tbl_busy", busy, tbl[i].bz);
         chk1("tbl_ready", digit_ready, ~tbl[i].bz);
         repeat (P + G) tick(acc);
      end

      // Back-to-back digits 3 then 9 with valid held high.
      wait_ready();
      digit       = 4'd3;
      digit_valid = 1'b1;
      tick(acc);
      digit = 4'd9;
      n_a = (tenkey == 10'h008) ? 1 : 0;
      n_b = 0;
      for (int i = 0; i < 13; i++) begin
         tick(acc);
         if (acc) digit_valid = 1'b0;
         if (tenkey == 10'h008) n_a++;
         if (tenkey == 10'h200) n_b++;
      end
      chk("b2b_press3_cycles", 10'(n_a), 10'd4);
      chk("b2b_press9_cycles", 10'(n_b), 10'd4);
      chk1("b2b_valid_consumed", digit_valid, 1'b0);

      // Reset during the second press cycle of digit 5, then digit 1.
      wait_ready();
      digit       = 4'd5;
      digit_valid = 1'b1;
      tick(acc);
      digit_valid = 1'b0;
      tick(acc);
      chk("mid_press_tenkey", tenkey, 10'h020);
      apply_reset();
      digit       = 4'd1;
      digit_valid = 1'b1;
      tick(acc);
      digit_valid = 1'b0;
      n_a = (tenkey == 10'h002) ? 1 : 0;
      for (int i = 0; i < 7; i++) begin
         tick(acc);
         if (tenkey == 10'h002) n_a++;
      end
      chk("post_rst_press_cycles", 10'(n_a), 10'd4);

      // Shortest timing: one press cycle, one gap cycle.
      chk1("d1_ready_idle", d1_ready, 1'b1);
      d1_digit = 4'd0;
      d1_valid = 1'b1;
      tick(acc);
      d1_valid = 1'b0;
      chk("d1_tenkey_c1", d1_tenkey, 10'h001);
      chk1("d1_ready_c1", d1_ready, 1'b0);
      chk1("d1_err_c1", d1_err, 1'b0);
      chk1("d1_close_c1", d1_close, 1'b0);
      tick(acc);
      chk("d1_tenkey_c2", d1_tenkey, 10'h000);
      chk1("d1_busy_c2", d1_busy, 1'b1);
      chk1("d1_ready_c2", d1_ready, 1'b0);
      tick(acc);
      chk1("d1_ready_c3", d1_ready, 1'b1);
      chk1("d1_busy_c3", d1_busy, 1'b0);
      chk("d1_tenkey_c3", d1_tenkey, 10'h000);

      // Random traffic; digit held stable until the model sees it accepted.
      for (int i = 0; i < 1500; i++) begin
         if (!digit_valid && $urandom_range(0, 2) == 0) begin
            digit       = 4'($urandom_range(0, 15));
            digit_valid = 1'b1;
         end
         tick(acc);
         if (acc) begin
            digit_valid = ($urandom_range(0, 1) == 1);
            digit       = 4'($urandom_range(0, 15));
         end
      end
      digit_valid = 1'b0;
      repeat (P + G + 2) tick(acc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
